// File: rtl/pause_dim_ctrl.sv
// pause_dim_ctrl: merges user, OSD and external pause sources into one
// registered pause_cpu. After a programmable idle time, it dims the RGB path.
// Optional macro PAUSE_VBL_SYNC_EN: when defined, pause_cpu only changes at
// the rising edge of vblank, so pause assertion and release are frame-aligned.
module pause_dim_ctrl #(
  parameter int RW          = 3,
  parameter int GW          = 3,
  parameter int BW          = 2,
  parameter int NREQ        = 2,
  parameter int TICK_CYCLES = 18_000_000,
  parameter int DIM_TICKS   = 10,
  parameter int DIM_SHIFT   = 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                user_button,
  input  logic [NREQ-1:0]     pause_request,
  input  logic                OSD_STATUS,
  input  logic [1:0]          options,
  input  logic                vblank,
  input  logic [RW+GW+BW-1:0] rgb_in,
  output logic [RW+GW+BW-1:0] rgb_out,
  output logic                pause_cpu,
  output logic                dim_video
);

  localparam int CW = RW + GW + BW;
  // Keep the prescaler at least one bit wide so TICK_CYCLES=1 still elaborates.
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = $clog2(DIM_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] SEC_MAX   = SW'(DIM_TICKS);

  logic          btn_d;
  logic          user_paused;
  logic          want;
  logic          idle;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] sec_cnt;

  // Only user or OSD pause counts as idle; an external request such as the
  // hiscore save must never dim the picture.
  assign want = user_paused | (|pause_request) | (options[0] & OSD_STATUS);
  assign idle = pause_cpu & (user_paused | (options[0] & OSD_STATUS));

  // Button edge detection; each rising edge toggles the user pause state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      btn_d       <= 1'b0;
      user_paused <= 1'b0;
    end else begin
      btn_d <= user_button;
      if (user_button & ~btn_d)
        user_paused <= ~user_paused;
    end
  end

`ifdef PAUSE_VBL_SYNC_EN
  logic vbl_d;

  // Pause output only reloads at the rising edge of vblank and holds otherwise.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vbl_d     <= 1'b0;
      pause_cpu <= 1'b0;
    end else begin
      vbl_d <= vblank;
      if (vblank & ~vbl_d)
        pause_cpu <= want;
    end
  end
`else
  // vblank has no function without frame alignment.
  logic unused_vblank;
  assign unused_vblank = vblank;

  // Pause output follows the merged request every cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      pause_cpu <= 1'b0;
    else
      pause_cpu <= want;
  end
`endif

  // Idle timer: the prescaler produces ticks, and sec_cnt saturates at DIM_TICKS.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      sec_cnt  <= '0;
    end else if (!idle) begin
      tick_cnt <= '0;
      sec_cnt  <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      if (sec_cnt != SEC_MAX)
        sec_cnt <= sec_cnt + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Each channel is shifted on its own slice, so no bits bleed from one
  // colour channel into the next. A shift at least as wide as the channel
  // yields zero.
  logic [RW-1:0] r_dim;
  logic [GW-1:0] g_dim;
  logic [BW-1:0] b_dim;
  assign r_dim = rgb_in[CW-1 -: RW] >> DIM_SHIFT;
  assign g_dim = rgb_in[BW +: GW] >> DIM_SHIFT;
  assign b_dim = rgb_in[0 +: BW] >> DIM_SHIFT;

  // The dim flag is registered, and the RGB register uses the flag value
  // already visible.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dim_video <= 1'b0;
      rgb_out   <= '0;
    end else begin
      dim_video <= options[1] & idle & (sec_cnt == SEC_MAX);
      rgb_out   <= dim_video ? {r_dim, g_dim, b_dim} : rgb_in;
    end
  end

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Directed testbench for pause_dim_ctrl with small timer parameters
// (TICK_CYCLES=100, DIM_TICKS=3), so dimming occurs 301 cycles after pause.
module tb_pause_dim_ctrl;

  logic       clk_sys;
  logic       reset_n;
  logic       user_button;
  logic [1:0] pause_request;
  logic       OSD_STATUS;
  logic [1:0] options;
  logic       vblank;
  logic [7:0] rgb_in;
  logic [7:0] rgb_out;
  logic       pause_cpu;
  logic       dim_video;

  int checks = 0;
  int errors = 0;
  int dim_seen;

  pause_dim_ctrl #(
    .RW(3), .GW(3), .BW(2), .NREQ(2),
    .TICK_CYCLES(100), .DIM_TICKS(3), .DIM_SHIFT(1)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .user_button(user_button),
    .pause_request(pause_request),
    .OSD_STATUS(OSD_STATUS),
    .options(options),
    .vblank(vblank),
    .rgb_in(rgb_in),
    .rgb_out(rgb_out),
    .pause_cpu(pause_cpu),
    .dim_video(dim_video)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Advance one clock, then settle 1 ns past the edge before sampling.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
    end else begin
      $display("ok   %s value=%0h t=%0t", tag, observed, $time);
    end
  endtask

  // Press the button for one cycle: edge 1 toggles user_paused, and edge 2
  // shows the toggle on pause_cpu.
  task automatic press();
    user_button = 1'b1;
    tick();
    user_button = 1'b0;
    tick();
  endtask

  initial begin
    reset_n       = 1'b0;
    user_button   = 1'b0;
    pause_request = 2'b00;
    OSD_STATUS    = 1'b0;
    options       = 2'b00;
    vblank        = 1'b0;
    rgb_in        = 8'h00;
    repeat (3) tick();
    check_val("rst_pause", {31'd0, pause_cpu}, 32'd0);
    check_val("rst_dim", {31'd0, dim_video}, 32'd0);
    check_val("rst_rgb", {24'd0, rgb_out}, 32'd0);
    reset_n = 1'b1;
    tick();

`ifdef PAUSE_VBL_SYNC_EN
    // Frame-aligned pause: a request waits for the next vblank rising edge.
    pause_request = 2'b10;
    repeat (100) tick();
    check_val("vbl_wait", {31'd0, pause_cpu}, 32'd0);
    vblank = 1'b1;
    tick();
    check_val("vbl_rise_on", {31'd0, pause_cpu}, 32'd1);
    pause_request = 2'b00;
    tick();
    check_val("vbl_hold_hi", {31'd0, pause_cpu}, 32'd1);
    vblank = 1'b0;
    repeat (5) tick();
    check_val("vbl_hold_lo", {31'd0, pause_cpu}, 32'd1);
    vblank = 1'b1;
    tick();
    check_val("vbl_rise_off", {31'd0, pause_cpu}, 32'd0);
    vblank = 1'b0;
    press();
    check_val("vbl_btn_wait", {31'd0, pause_cpu}, 32'd0);
    vblank = 1'b1;
    tick();
    check_val("vbl_btn_on", {31'd0, pause_cpu}, 32'd1);
    vblank = 1'b0;
    tick();
    reset_n = 1'b0;
    #2;
    check_val("vbl_async_rst", {31'd0, pause_cpu}, 32'd0);
    reset_n = 1'b1;
    tick();
    vblank = 1'b1;
    tick();
    check_val("vbl_post_rst", {31'd0, pause_cpu}, 32'd0);
`else
    // Button toggle: the toggle appears on pause_cpu one cycle after the edge.
    user_button = 1'b1;
    tick();
    check_val("btn_lat0", {31'd0, pause_cpu}, 32'd0);
    user_button = 1'b0;
    tick();
    check_val("btn_on", {31'd0, pause_cpu}, 32'd1);
    user_button = 1'b1;
    tick();
    check_val("btn_lat1", {31'd0, pause_cpu}, 32'd1);
    user_button = 1'b0;
    tick();
    check_val("btn_off", {31'd0, pause_cpu}, 32'd0);

    // Dim timer: with user pause, dim_video goes high 301 cycles after pause_cpu.
    options = 2'b11;
    press();
    check_val("dim_pause", {31'd0, pause_cpu}, 32'd1);
    repeat (300) tick();
    check_val("dim_early", {31'd0, dim_video}, 32'd0);
    tick();
    check_val("dim_on", {31'd0, dim_video}, 32'd1);
    rgb_in = 8'b111_111_11;
    tick();
    check_val("rgb_dim_ff", {24'd0, rgb_out}, {24'd0, 8'b011_011_01});
    rgb_in = 8'b101_110_10;
    tick();
    check_val("rgb_dim_mix", {24'd0, rgb_out}, {24'd0, 8'b010_011_01});
    rgb_in = 8'b001_001_01;
    tick();
    check_val("rgb_no_bleed", {24'd0, rgb_out}, {24'd0, 8'b000_000_00});
    // Clearing dim enable drops dim_video but keeps the counters.
    options = 2'b01;
    rgb_in  = 8'hff;
    tick();
    check_val("dim_en_off", {31'd0, dim_video}, 32'd0);
    tick();
    check_val("rgb_pass", {24'd0, rgb_out}, 32'h0000_00ff);
    options = 2'b11;
    tick();
    check_val("dim_en_back", {31'd0, dim_video}, 32'd1);

    // Asynchronous reset between clock edges while dimmed.
    reset_n = 1'b0;
    #2;
    check_val("arst_pause", {31'd0, pause_cpu}, 32'd0);
    check_val("arst_dim", {31'd0, dim_video}, 32'd0);
    check_val("arst_rgb", {24'd0, rgb_out}, 32'd0);
    reset_n = 1'b1;
    repeat (5) tick();
    check_val("arst_stay", {31'd0, pause_cpu}, 32'd0);
    check_val("arst_rgb_pass", {24'd0, rgb_out}, 32'h0000_00ff);

    // External request only: pause without dimming. vblank toggles are ignored.
    pause_request = 2'b10;
    tick();
    check_val("ext_on", {31'd0, pause_cpu}, 32'd1);
    dim_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      vblank = i[3];
      tick();
      if (dim_video) dim_seen = 1;
    end
    check_val("ext_no_dim", dim_seen, 32'd0);
    check_val("ext_held", {31'd0, pause_cpu}, 32'd1);
    pause_request = 2'b00;
    tick();
    check_val("ext_off", {31'd0, pause_cpu}, 32'd0);

    // Simultaneous events.
    pause_request = 2'b01;
    tick();
    press();
    check_val("sim_req_btn", {31'd0, pause_cpu}, 32'd1);
    pause_request = 2'b00;
    tick();
    check_val("sim_user_holds", {31'd0, pause_cpu}, 32'd1);
    user_button = 1'b1;
    tick();
    user_button = 1'b0;
    tick();
    check_val("sim_btn_release", {31'd0, pause_cpu}, 32'd0);

    // OSD pause depends on options[0].
    options    = 2'b00;
    OSD_STATUS = 1'b1;
    tick();
    check_val("osd_disabled", {31'd0, pause_cpu}, 32'd0);
    options = 2'b01;
    tick();
    check_val("osd_on", {31'd0, pause_cpu}, 32'd1);
    options = 2'b11;
    repeat (300) tick();
    check_val("osd_dim_early", {31'd0, dim_video}, 32'd0);
    tick();
    check_val("osd_dim_on", {31'd0, dim_video}, 32'd1);
    options = 2'b01;
    tick();
    check_val("osd_dim_off", {31'd0, dim_video}, 32'd0);
    OSD_STATUS = 1'b0;
    tick();
    check_val("osd_close", {31'd0, pause_cpu}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
